btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Parametrised input conditioner for N raw board pushbuttons (btnL, btnR, btnC, etc.), placed between the FPGA pins and the game core in the 65 MHz domain.
- Each channel gets four stages in order: a multi-flop synchroniser, a counter-based debouncer, press/release edge pulses, and optionally hold-to-repeat pulses for player movement.
- Replaces passing raw asynchronous buttons straight into functional logic.

Parameters:
- N_BTN, 2, number of independent button channels.
- SYNC_STAGES, 2, synchroniser flop depth; must be >= 2.
- DEBOUNCE_CYCLES, 650000, consecutive mismatching cycles needed to accept a new level (10 ms at 65 MHz); must be >= 1.
- REPEAT_DELAY, 26000000, cycles from press pulse to first repeat pulse (0.4 s); used only with BTN_AUTOREPEAT_EN.
- REPEAT_PERIOD, 6500000, cycles between subsequent repeat pulses (0.1 s); used only with BTN_AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock (65 MHz pixel clock domain)
- rst_n  input  1  reset, asynchronous, active-low
- btn_raw  input  N_BTN  raw asynchronous button pins, active-high
- btn_level  output  N_BTN  debounced level
- btn_press  output  N_BTN  1-cycle pulse on debounced 0->1
- btn_release  output  N_BTN  1-cycle pulse on debounced 1->0
- btn_repeat  output  N_BTN  1-cycle auto-repeat pulse while held

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low. While rst_n=0, all synchroniser flops, debounce counters, btn_level, btn_press, btn_release and btn_repeat are 0, and every repeat state machine is IDLE. Release from reset is synchronous to clk. Reset asserted mid-debounce or mid-hold discards all progress, with no pulses emitted.
- Channels are fully independent. Simultaneous events on several channels are handled per channel in the same cycle.
- Synchroniser: btn_raw[i] passes through SYNC_STAGES flops to give sync[i].
- Debouncer, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If sync == btn_level, the counter clears to 0.
  - If sync != btn_level and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If sync != btn_level and counter == DEBOUNCE_CYCLES-1, btn_level toggles and the counter clears.
  - Any single cycle of agreement restarts the count, so a glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Latency: a clean raw change first sampled at edge 0 appears on btn_level after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Edge pulses:
  - btn_press is high for exactly the one cycle in which btn_level first reads 1 after a 0; btn_release likewise on 1->0.
  - Both are registered and aligned with the btn_level change.
  - They are never both high on the same channel.
- Repeat FSM, per channel:
  - States: IDLE, DELAY, REPEAT. Counter width is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
  - IDLE -> DELAY on the press pulse; the counter loads 0.
  - DELAY: the counter increments each cycle. When it reaches REPEAT_DELAY-1, emit btn_repeat for one cycle, go to REPEAT, and clear the counter.
  - REPEAT: emit btn_repeat every REPEAT_PERIOD cycles.
  - Any state -> IDLE in the cycle btn_level reads 0 (release). No repeat pulse is emitted in the release cycle.
  - btn_repeat never coincides with btn_press.
- Counters never wrap; every path clears them explicitly.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: the repeat FSMs and counters are built, and btn_repeat behaves as above.
- Undefined: no repeat logic is synthesised. btn_repeat is tied to constant 0 and the port list is unchanged. REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan (bench overrides: N_BTN=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press: btn_raw[0] goes 0->1 before edge 0 and stays high -> btn_level[0]=1 and btn_press[0]=1 after edge 6; btn_press[0] is 0 after edge 7; channel 1 stays at 0 throughout.
- Bounce rejection: btn_raw[0] is high for 3 cycles, low for 1, then high steadily -> btn_level rises only 6 edges after the final rising sample; exactly one btn_press, no btn_release.
- Release and simultaneity: both channels held, then both btn_raw drop on the same edge -> btn_release[1:0]=2'b11 in the same cycle, 6 edges later; btn_level=0.
- Reset mid-debounce: rst_n pulled low 2 cycles after a raw press, then released -> all outputs 0 for at least 6 cycles after rst_n rises, then the press is accepted normally if raw is still high; no spurious pulses.
- Auto-repeat (macro defined): hold btn_raw[1] -> first btn_repeat[1] 10 cycles after btn_press[1], then every 3 cycles; release -> btn_repeat stops, none in the release cycle.
- Auto-repeat (macro undefined): same hold for 50 cycles -> btn_repeat stays 2'b00; press and release pulses are unchanged.

Source files
------------

// File: rtl/btn_if.sv
// btn_if: groups the raw button pins and the conditioned outputs of one button bank.
//   btn_raw     raw asynchronous button pins, active-high
//   btn_level   debounced level
//   btn_press   1-cycle pulse on debounced 0->1
//   btn_release 1-cycle pulse on debounced 1->0
//   btn_repeat  1-cycle auto-repeat pulse while held
//   master: pin/consumer side, slave: conditioner side
interface btn_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;
    modport master (output btn_raw, input btn_level, btn_press, btn_release, btn_repeat);
    modport slave (input btn_raw, output btn_level, btn_press, btn_release, btn_repeat);
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel synchroniser, debouncer, press/release pulses and optional auto-repeat.
//   clk   system clock
//   rst_n asynchronous active-low reset
//   bus   btn_if.slave: btn_raw in; btn_level, btn_press, btn_release, btn_repeat out
//   Define BTN_AUTOREPEAT_EN to build the hold-to-repeat logic; otherwise btn_repeat is 0.
module btn_conditioner #(
    parameter int N_BTN           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 26000000,
    parameter int REPEAT_PERIOD   = 6500000
) (
    input logic clk,
    input logic rst_n,
    btn_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("btn_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q;
    logic [N_BTN-1:0] sync, mis, hit, level_q, press_q, rel_q;
    logic [DW-1:0] dcnt_q [N_BTN];

    assign sync = sync_q[SYNC_STAGES-1];
    assign mis  = sync ^ level_q;

    // hit: the mismatch has now persisted for DEBOUNCE_CYCLES consecutive cycles
    always_comb begin
        hit = '0;
        for (int k = 0; k < N_BTN; k++)
            hit[k] = mis[k] && dcnt_q[k] == DW'(DEBOUNCE_CYCLES - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int k = 0; k < N_BTN; k++)
                dcnt_q[k] <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.btn_raw};
            level_q <= level_q ^ hit;
            press_q <= hit & ~level_q;
            rel_q   <= hit & level_q;
            for (int k = 0; k < N_BTN; k++)
                dcnt_q[k] <= (mis[k] && !hit[k]) ? dcnt_q[k] + 1'b1 : '0;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = rel_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
        $error("btn_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

    rep_state_e st_q [N_BTN];
    rep_state_e st_d [N_BTN];
    logic [RW-1:0] rc_q [N_BTN];
    logic [RW-1:0] rc_d [N_BTN];
    logic [N_BTN-1:0] rise, fall, rep_q, rep_d;

    // rise/fall are the same events that register btn_press/btn_release,
    // so the FSM enters DELAY in step with the press pulse
    assign rise = hit & ~level_q;
    assign fall = hit & level_q;

    always_comb begin
        rep_d = '0;
        for (int k = 0; k < N_BTN; k++) begin
            st_d[k] = st_q[k];
            rc_d[k] = rc_q[k];
            if (fall[k]) begin
                st_d[k] = IDLE;
                rc_d[k] = '0;
            end else begin
                case (st_q[k])
                    IDLE: begin
                        if (rise[k]) begin
                            st_d[k] = DELAY;
                            rc_d[k] = '0;
                        end
                    end
                    DELAY: begin
                        if (rc_q[k] == RW'(REPEAT_DELAY - 1)) begin
                            rep_d[k] = 1'b1;
                            st_d[k]  = REPEAT;
                            rc_d[k]  = '0;
                        end else begin
                            rc_d[k] = rc_q[k] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rc_q[k] == RW'(REPEAT_PERIOD - 1)) begin
                            rep_d[k] = 1'b1;
                            rc_d[k]  = '0;
                        end else begin
                            rc_d[k] = rc_q[k] + 1'b1;
                        end
                    end
                    default: begin
                        st_d[k] = IDLE;
                        rc_d[k] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
            for (int k = 0; k < N_BTN; k++) begin
                st_q[k] <= IDLE;
                rc_q[k] <= '0;
            end
        end else begin
            rep_q <= rep_d;
            for (int k = 0; k < N_BTN; k++) begin
                st_q[k] <= st_d[k];
                rc_q[k] <= rc_d[k];
            end
        end
    end

    assign bus.btn_repeat = rep_q;
`else
    // repeat timing is unused in this build; still reject nonsense values
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_bad_rep
        $error("btn_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be non-negative");
    end

    assign bus.btn_repeat = '0;
`endif
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: randomized and directed stimulus checked against an edge-indexed reference model.
module tb_btn_conditioner;
    localparam int NB = 2;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btn_if #(.N_BTN(NB)) bus ();

    btn_conditioner #(
        .N_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Reference model: raw history indexed by edge number since reset release.
    // A channel's level flips once the delayed raw value has disagreed with it
    // for DC consecutive edges; repeats follow from edge distance to the press.
    logic [NB-1:0] hist [$];
    logic [NB-1:0] m_level, m_press, m_rel, m_rep;
    int run [NB];
    int pedge [NB];

    task automatic model_reset();
        hist.delete();
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
        m_rep   = '0;
        for (int c = 0; c < NB; c++) begin
            run[c]   = 0;
            pedge[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [NB-1:0] s;
        int k;
`ifdef BTN_AUTOREPEAT_EN
        int d;
`endif
        k = hist.size();
        s = (k >= SS) ? hist[k-SS] : '0;
        hist.push_back(bus.btn_raw);
        m_press = '0;
        m_rel   = '0;
        m_rep   = '0;
        for (int c = 0; c < NB; c++) begin
            run[c] = (s[c] != m_level[c]) ? run[c] + 1 : 0;
            if (run[c] == DC) begin
                run[c] = 0;
                m_level[c] = ~m_level[c];
                if (m_level[c]) begin
                    m_press[c] = 1'b1;
                    pedge[c] = k;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            if (m_level[c] && !m_press[c]) begin
                d = k - pedge[c];
                m_rep[c] = (d == RD) || (d > RD && (d - RD) % RP == 0);
            end
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check("level", bus.btn_level, m_level);
        check("press", bus.btn_press, m_press);
        check("release", bus.btn_release, m_rel);
        check("repeat", bus.btn_repeat, m_rep);
        check("press_and_release", bus.btn_press & bus.btn_release, '0);
        check("repeat_and_press", bus.btn_repeat & bus.btn_press, '0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic async_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_level", bus.btn_level, '0);
        check("async_rst_pulses", bus.btn_press | bus.btn_release | bus.btn_repeat, '0);
        model_reset();
        ticks(cycles);
        rst_n = 1'b1;
    endtask

    task automatic set_raw(input int c, input logic v);
        logic [NB-1:0] r;
        r = bus.btn_raw;
        r[c] = v;
        bus.btn_raw = r;
    endtask

    initial begin
        bus.btn_raw = '0;
        model_reset();
        ticks(3);
        rst_n = 1'b1;
        ticks(8);

        // clean press on channel 0
        set_raw(0, 1'b1);
        ticks(5);
        check("cp_level_before", bus.btn_level, 2'b00);
        tick();
        check("cp_level", bus.btn_level, 2'b01);
        check("cp_press", bus.btn_press, 2'b01);
        tick();
        check("cp_press_gone", bus.btn_press, 2'b00);
        ticks(3);
        set_raw(0, 1'b0);
        ticks(10);

        // bounce: high 3, low 1, then high steadily
        set_raw(0, 1'b1);
        ticks(3);
        set_raw(0, 1'b0);
        tick();
        set_raw(0, 1'b1);
        ticks(5);
        check("bounce_level_before", bus.btn_level, 2'b00);
        tick();
        check("bounce_press", bus.btn_press, 2'b01);
        ticks(4);

        // simultaneous release on both channels
        set_raw(1, 1'b1);
        ticks(10);
        check("sim_held", bus.btn_level, 2'b11);
        bus.btn_raw = 2'b00;
        ticks(5);
        check("sim_release_before", bus.btn_release, 2'b00);
        tick();
        check("sim_release", bus.btn_release, 2'b11);
        check("sim_level", bus.btn_level, 2'b00);
        ticks(6);

        // reset mid-debounce, raw stays high
        set_raw(0, 1'b1);
        ticks(2);
        async_reset(2);
        ticks(5);
        check("rst_level_held_low", bus.btn_level, 2'b00);
        tick();
        check("rst_press_after", bus.btn_press, 2'b01);
        set_raw(0, 1'b0);
        ticks(10);

        // long hold on channel 1
        set_raw(1, 1'b1);
        ticks(6);
        check("hold_press", bus.btn_press, 2'b10);
        ticks(9);
        check("hold_no_early_repeat", bus.btn_repeat, 2'b00);
        tick();
`ifdef BTN_AUTOREPEAT_EN
        check("hold_first_repeat", bus.btn_repeat, 2'b10);
`else
        check("hold_first_repeat", bus.btn_repeat, 2'b00);
`endif
        ticks(35);
        set_raw(1, 1'b0);
        ticks(12);

        // randomized phases alternating between bouncy and long-hold behaviour
        for (int t = 0; t < 1500; t++) begin
            int den;
            den = ((t / 300) % 2) ? 30 : 5;
            for (int c = 0; c < NB; c++)
                if ($urandom_range(den - 1, 0) == 0) set_raw(c, ~bus.btn_raw[c]);
            if ($urandom_range(399, 0) == 0) async_reset($urandom_range(3, 1));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
